fp_mult_arbiter: RTL and testbench
==================================

Name: fp_mult_arbiter

Overview:
- Shares one pipelined FP multiplier datapath (unpack, mantissa product, normalize, round, pack) between NUM_REQ requesters.
- Per requester: valid/ready request channel, valid/ready response channel, at most one operation outstanding.
- Round-robin grant of one issue per cycle, in-flight ID tracking, result steering into per-requester holding registers.
- Sits between the vector/scalar issue logic and the shared fp_mult instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- sig_width, 23, stored mantissa bits.
- ex_width, 8, exponent bits.
- MULT_LAT, 3, fixed register-stage latency of the attached multiplier (>=1), operands to result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid per requester.
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready.
- req_a  in  NUM_REQ x W  operand A per requester, W = sig_width+ex_width+1.
- req_b  in  NUM_REQ x W  operand B per requester.
- rsp_valid  out  NUM_REQ  result held for requester.
- rsp_ready  in  NUM_REQ  requester accepts result.
- rsp_data  out  NUM_REQ x W  result per requester.
- mul_in_valid  out  1  issue strobe to multiplier.
- mul_a, mul_b  out  W  muxed operands of granted requester.
- mul_out  in  W  multiplier result, valid MULT_LAT cycles after issue.

Behaviour:
- Reset (async assert): req_ready=0, rsp_valid=0, rsp_data=0, mul_in_valid=0, busy=0, tag pipe cleared, rr pointer=0. In-flight operations are discarded; results arriving after reset release are ignored because tag valids are 0.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i], using the registered busy.
- Grant (combinational): first eligible index searching upward from rr_ptr with wrap-around. req_ready = one-hot of the grant, or 0 if none eligible.
- mul_in_valid = |req_ready. mul_a/mul_b = operands of the granted index, otherwise 0.
- On grant of index g at edge t:
  - busy[g] <= 1.
  - Tag pipe stage 0 <= {valid=1, id=g}.
  - rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged when nothing is granted.
- Tag pipe: MULT_LAT-deep shift register of {valid, id}, shifting every cycle, no stall. Its last stage is aligned with mul_out.
- On tag-out valid with id k: rsp_data[k] <= mul_out, rsp_valid[k] <= 1. Response appears MULT_LAT+1 cycles after the grant cycle.
- Response handshake on rsp_valid[k]&rsp_ready[k]: rsp_valid[k] <= 0, busy[k] <= 0. rsp_data holds its value until overwritten. Requester k can be regranted no earlier than the next cycle (one-cycle bubble by design).
- Boundaries:
  - No result collides with a full slot, since busy blocks a second issue.
  - rsp_ready while rsp_valid=0 is ignored.
  - req_valid dropping before grant is legal; nothing is issued.
  - All requesters busy: no issue; the multiplier pipe drains.
  - NUM_REQ=1 degenerates to one issue per MULT_LAT+2 cycles.
- Throughput: one issue per cycle while at least NUM_REQ eligible requesters exist.

Optional Feature:
- Macro FP_MULT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index wins; rr_ptr is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package fp_mult_arb_pkg holds:
  - localparam functions for W and id width ($clog2(NUM_REQ), minimum 1).
  - typedef tag_t {logic valid; logic [IDW-1:0] id;}.
- One sub-module: rr_arbiter, holding the pointer register and the masked/unmasked priority-encode producing the one-hot grant. Under FP_MULT_ARB_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Single op, requester 0: a=0x3F800000 (1.0), b=0x40000000 (2.0) granted at cycle 0 -> rsp_valid[0] at cycle MULT_LAT+1 with rsp_data[0]=0x40000000; rsp_ready -> busy cleared.
- All 4 requesters valid at cycle 0, each 0x3FC00000 x 0x3FC00000 (1.5^2):
  - round-robin build: grants 0,1,2,3 on consecutive cycles.
  - FP_MULT_ARB_FIXED_PRIO_EN build: same order (each requester is blocked by busy after its grant).
  - In both builds every rsp_data = 0x40100000 (2.25), arriving in grant order.
- Back-pressure: requester 1 holds rsp_ready=0 for 10 cycles with req_valid kept high -> no second grant to 1, result stays stable, the others continue to be served; on acceptance, regrant the following cycle.
- Fairness: requesters 0 and 2 continuously valid with rsp_ready=1 -> grants alternate 0,2,0,2, with no requester starved more than NUM_REQ cycles beyond its bubble.
- Reset mid-flight: assert rst_n=0 one cycle after two issues -> all outputs 0 immediately; after release, no rsp_valid appears from the discarded operations.

Source files
------------

// File: rtl/fp_mult_arb_pkg.sv
// Shared definitions for the fp_mult_arbiter slice.
//   calc_w   : operand/result width from mantissa and exponent widths.
//   calc_idw : requester-id width, $clog2(num_req) with a minimum of 1.
//   tag_t    : in-flight tag carried alongside the multiplier pipe.
package fp_mult_arb_pkg;

  // Requester ids are stored at a fixed width that covers the largest legal
  // requester count (8); narrower configurations leave the top bits zero.
  localparam int unsigned IDW = 3;

  function automatic int unsigned calc_w(int unsigned sig_width, int unsigned ex_width);
    return sig_width + ex_width + 1;
  endfunction

  function automatic int unsigned calc_idw(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// One-hot grant generator for the shared multiplier.
// Default build: round-robin. The search starts at the pointer (masked
// priority encode); if nothing at or above the pointer is eligible, the
// unmasked request vector is used. The pointer moves to one past the granted
// index and holds when nothing is granted.
// With FP_MULT_ARB_FIXED_PRIO_EN defined: plain priority encoder, the lowest
// eligible index wins, and there is no pointer state.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer only)
//   eligible   : per-requester eligibility
//   grant      : one-hot grant, or zero when nothing is eligible
module rr_arbiter
  import fp_mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] eligible,
  output logic [NUM_REQ-1:0] grant
);

`ifdef FP_MULT_ARB_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  localparam int unsigned PW = calc_idw(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic          found;
    logic [PW-1:0] gidx;
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    // Masked pass: indices at or above the pointer.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i] && (PW'(i) >= ptr_q)) begin
        grant[i] = 1'b1;
        gidx     = PW'(i);
        found    = 1'b1;
      end
    end
    // Unmasked pass covers the wrap-around.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i]) begin
        grant[i] = 1'b1;
        gidx     = PW'(i);
        found    = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined FP multiplier between NUM_REQ requesters. Each
// requester may have a single operation outstanding; one issue per cycle is
// granted, a tag pipe matched to the multiplier latency tracks the owner, and
// the result lands in that requester's holding register until accepted.
// Optional: FP_MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin (see rr_arbiter).
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   req_valid/req_ready     : per-requester issue handshake (ready is the grant)
//   req_a, req_b            : per-requester operands
//   rsp_valid/rsp_ready     : per-requester result handshake
//   rsp_data                : per-requester held result
//   mul_in_valid, mul_a/b   : issue to the shared multiplier
//   mul_out                 : multiplier result, MULT_LAT cycles after issue
module fp_mult_arbiter
  import fp_mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned sig_width = 23,
  parameter int unsigned ex_width  = 8,
  parameter int unsigned MULT_LAT  = 3,
  localparam int unsigned W        = calc_w(sig_width, ex_width)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0][W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ-1:0][W-1:0]   rsp_data,
  output logic                        mul_in_valid,
  output logic [W-1:0]                mul_a,
  output logic [W-1:0]                mul_b,
  input  logic [W-1:0]                mul_out
);

  logic [NUM_REQ-1:0]        busy_q, busy_d;
  logic [NUM_REQ-1:0]        eligible, grant;
  logic [IDW-1:0]            grant_id;
  tag_t [MULT_LAT-1:0]       tag_q, tag_d;
  tag_t                      tag_out;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][W-1:0] rsp_data_q, rsp_data_d;

  // Nothing is offered while reset is held, so req_ready reads 0 immediately.
  assign eligible = req_valid & ~busy_q & {NUM_REQ{rst_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready    = grant;
  assign mul_in_valid = |grant;

  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_a    = req_a[i];
        mul_b    = req_b[i];
        grant_id = IDW'(i);
      end
    end
  end

  // Tag pipe: stage MULT_LAT-1 lines up with mul_out.
  always_comb begin
    tag_d          = tag_q;
    tag_d[0].valid = mul_in_valid;
    tag_d[0].id    = grant_id;
    for (int s = 1; s < MULT_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  assign tag_out = tag_q[MULT_LAT-1];

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q | grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rsp_valid_q[k] && rsp_ready[k]) begin
        rsp_valid_d[k] = 1'b0;
        busy_d[k]      = 1'b0;
      end
      // Busy guarantees the slot is empty when its result arrives.
      if (tag_out.valid && (tag_out.id == IDW'(k))) begin
        rsp_valid_d[k] = 1'b1;
        rsp_data_d[k]  = mul_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
module tb_fp_mult_arbiter;

  localparam int N = 4;
  localparam int L = 3;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][W-1:0] req_a, req_b, rsp_data;
  logic                mul_in_valid;
  logic [W-1:0]        mul_a, mul_b, mul_out;

  int n_cmp = 0;
  int n_err = 0;

  fp_mult_arbiter #(
    .NUM_REQ   (N),
    .sig_width (23),
    .ex_width  (8),
    .MULT_LAT  (L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .mul_in_valid (mul_in_valid),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_out      (mul_out)
  );

  always #5 clk = ~clk;

  // ---------------- float32 multiply via double precision ----------------
  // Operands are kept normal with moderate exponents, so the double product
  // is exact and a single round-to-nearest-even to float32 is correct.
  function automatic real f2r(input logic [31:0] a);
    int          e;
    logic [63:0] d;
    e = int'(a[30:23]) + 896;
    d = {a[31], e[10:0], a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [23:0] m;
    logic [28:0] low;
    int          e;
    d   = $realtobits(f2r(a) * f2r(b));
    m   = {1'b0, d[51:29]};
    low = d[28:0];
    e   = int'(d[62:52]) - 896;
    if (low > 29'h1000_0000 || (low == 29'h1000_0000 && d[29])) m = m + 24'd1;
    if (m[23]) begin
      m = '0;
      e = e + 1;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r        = $urandom;
    r[30:23] = 8'($urandom_range(154, 100));
    return r;
  endfunction

  // Multiplier stand-in: L register stages, operands to result.
  logic [W-1:0] mpipe [L];
  always_ff @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int s = 1; s < L; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_out = mpipe[L-1];

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [31:0] data;
    int          cnt;
  } flight_t;

  flight_t     fq[$];
  logic [N-1:0] m_busy, m_rv;
  logic [31:0] m_rd [N];
  int          m_ptr;

  task automatic model_reset();
    fq.delete();
    m_busy = '0;
    m_rv   = '0;
    m_ptr  = 0;
    for (int k = 0; k < N; k++) m_rd[k] = '0;
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (rst_n !== 1'b1) return g;
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !m_busy[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
`else
    for (int o = 0; o < N; o++) begin
      int i;
      i = (m_ptr + o) % N;
      if (req_valid[i] && !m_busy[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
`endif
    return g;
  endfunction

  task automatic model_clock();
    logic [N-1:0] g;
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    g = model_grant();
    for (int k = 0; k < N; k++) begin
      if (m_rv[k] && rsp_ready[k]) begin
        m_rv[k]   = 1'b0;
        m_busy[k] = 1'b0;
      end
    end
    for (int j = fq.size() - 1; j >= 0; j--) begin
      fq[j].cnt = fq[j].cnt - 1;
      if (fq[j].cnt == 0) begin
        m_rv[fq[j].id] = 1'b1;
        m_rd[fq[j].id] = fq[j].data;
        fq.delete(j);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        flight_t f;
        f.id   = i;
        f.data = fmul(req_a[i], req_b[i]);
        f.cnt  = L;
        fq.push_back(f);
        m_busy[i] = 1'b1;
        m_ptr     = (i + 1) % N;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (idx != -1) return -2;
        idx = i;
      end
    end
    return idx;
  endfunction

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (L + 4) tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = rnd_op();
      req_b[i] = rnd_op();
    end
    model_reset();
    tick();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    n_cmp++;
    if (mul_in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mul_in_valid: got %b want 0", mul_in_valid);
    end
    n_cmp++;
    if (rsp_valid !== '0) begin
      n_err++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    n_cmp++;
    if (rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
    end
    tick();
    req_valid = '0;
    rsp_ready = '0;
    rst_n     = 1'b1;
  endtask

  task automatic test_single();
    int cyc;
    req_valid = 4'b0001;
    req_a[0]  = 32'h3F80_0000;
    req_b[0]  = 32'h4000_0000;
    rsp_ready = '0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || mul_a !== 32'h3F80_0000 || mul_b !== 32'h4000_0000) begin
      n_err++;
      $display("FAIL single_issue: got ready=%b a=%h b=%h want 0001 3f800000 40000000",
               req_ready, mul_a, mul_b);
    end
    tick();
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL single_busy_block: got %b want 0", req_ready);
    end
    req_valid = '0;
    cyc = 1;
    while (cyc <= 20) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc != L + 1) begin
      n_err++;
      $display("FAIL single_latency: got %0d want %0d", cyc, L + 1);
    end
    n_cmp++;
    if (rsp_data[0] !== 32'h4000_0000) begin
      n_err++;
      $display("FAIL single_data: got %h want 40000000", rsp_data[0]);
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0 || req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL single_release: got rsp_valid=%b ready=%b want 0 0001",
               rsp_valid[0], req_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_all4();
    int g_order[$];
    int a_order[$];
    logic [N-1:0] prev;
    do_reset();
    req_valid = '1;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'h3FC0_0000;
      req_b[i] = 32'h3FC0_0000;
    end
    prev = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready !== '0) g_order.push_back(oh_idx(req_ready));
      for (int k = 0; k < N; k++) if (rsp_valid[k] && !prev[k]) a_order.push_back(k);
      prev = rsp_valid;
      tick();
      if (c == 3) req_valid = '0;
    end
    n_cmp++;
    if (g_order.size() != N) begin
      n_err++;
      $display("FAIL all4_grant_count: got %0d want %0d", g_order.size(), N);
    end
    for (int i = 0; i < g_order.size() && i < N; i++) begin
      n_cmp++;
      if (g_order[i] != i) begin
        n_err++;
        $display("FAIL all4_grant_order[%0d]: got %0d want %0d", i, g_order[i], i);
      end
    end
    n_cmp++;
    if (a_order.size() != N) begin
      n_err++;
      $display("FAIL all4_arrival_count: got %0d want %0d", a_order.size(), N);
    end
    for (int i = 0; i < a_order.size() && i < N; i++) begin
      n_cmp++;
      if (a_order[i] != i) begin
        n_err++;
        $display("FAIL all4_arrival_order[%0d]: got %0d want %0d", i, a_order[i], i);
      end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== 32'h4010_0000) begin
        n_err++;
        $display("FAIL all4_data[%0d]: got v=%b %h want 1 40100000", k, rsp_valid[k], rsp_data[k]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int others;
    others    = 0;
    req_valid = '1;
    rsp_ready = 4'b1101;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i] = rnd_op();
        req_b[i] = rnd_op();
      end
      @(negedge clk);
      n_cmp++;
      if (req_ready !== model_grant() || rsp_valid !== m_rv) begin
        n_err++;
        $display("FAIL bp_cycle%0d: got ready=%b rv=%b want %b %b",
                 c, req_ready, rsp_valid, model_grant(), m_rv);
      end
      if (m_rv[1]) begin
        n_cmp++;
        if (rsp_data[1] !== m_rd[1] || req_ready[1] !== 1'b0) begin
          n_err++;
          $display("FAIL bp_hold%0d: got %h ready1=%b want %h 0", c, rsp_data[1], req_ready[1], m_rd[1]);
        end
      end
      if (req_ready[0] || req_ready[2] || req_ready[3]) others++;
      tick();
    end
    n_cmp++;
    if (others < 3) begin
      n_err++;
      $display("FAIL bp_others_served: got %0d want >=3", others);
    end
    req_valid = 4'b0010;
    rsp_ready = '1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[1] !== 1'b1 || m_rv[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_held_at_accept: got %b want 1", rsp_valid[1]);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_regrant: got %b want 0010", req_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_fairness();
    int seq[$];
    int last [N];
    int maxgap;
    do_reset();
    for (int i = 0; i < N; i++) last[i] = -1;
    maxgap    = 0;
    req_valid = 4'b0101;
    rsp_ready = '1;
    for (int c = 0; c < 40; c++) begin
      int g;
      req_a[0] = rnd_op();
      req_b[0] = rnd_op();
      req_a[2] = rnd_op();
      req_b[2] = rnd_op();
      @(negedge clk);
      n_cmp++;
      if (req_ready !== model_grant()) begin
        n_err++;
        $display("FAIL fair_ready%0d: got %b want %b", c, req_ready, model_grant());
      end
      g = oh_idx(req_ready);
      if (g >= 0) begin
        seq.push_back(g);
        if (last[g] >= 0 && c - last[g] > maxgap) maxgap = c - last[g];
        last[g] = c;
      end
      tick();
    end
    n_cmp++;
    if (seq.size() < 12) begin
      n_err++;
      $display("FAIL fair_count: got %0d want >=12", seq.size());
    end
    for (int j = 1; j < seq.size(); j++) begin
      n_cmp++;
      if (seq[j] == seq[j-1] || (seq[j] != 0 && seq[j] != 2)) begin
        n_err++;
        $display("FAIL fair_alternate[%0d]: got %0d after %0d", j, seq[j], seq[j-1]);
      end
    end
    n_cmp++;
    if (maxgap > L + 2 + N) begin
      n_err++;
      $display("FAIL fair_gap: got %0d want <=%0d", maxgap, L + 2 + N);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic [N-1:0] eg;
      logic [31:0]  ea, eb;
      req_valid = N'($urandom);
      rsp_ready = N'($urandom) | N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i] = rnd_op();
        req_b[i] = rnd_op();
      end
      @(negedge clk);
      eg = model_grant();
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          ea = req_a[i];
          eb = req_b[i];
        end
      end
      n_cmp++;
      if (req_ready !== eg || mul_in_valid !== (|eg)) begin
        n_err++;
        $display("FAIL rand_grant%0d: got %b/%b want %b/%b", c, req_ready, mul_in_valid, eg, |eg);
      end
      n_cmp++;
      if (mul_a !== ea || mul_b !== eb) begin
        n_err++;
        $display("FAIL rand_operands%0d: got %h %h want %h %h", c, mul_a, mul_b, ea, eb);
      end
      n_cmp++;
      if (rsp_valid !== m_rv) begin
        n_err++;
        $display("FAIL rand_rsp_valid%0d: got %b want %b", c, rsp_valid, m_rv);
      end
      for (int k = 0; k < N; k++) begin
        if (m_rv[k]) begin
          n_cmp++;
          if (rsp_data[k] !== m_rd[k]) begin
            n_err++;
            $display("FAIL rand_rsp_data%0d[%0d]: got %h want %h", c, k, rsp_data[k], m_rd[k]);
          end
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b0011;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = rnd_op();
      req_b[i] = rnd_op();
    end
    tick();
    tick();
    n_cmp++;
    if (fq.size() != 2) begin
      n_err++;
      $display("FAIL mid_two_issued: model in flight %0d want 2", fq.size());
    end
    req_valid = '0;
    tick();
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    n_cmp++;
    if (req_ready !== '0 || mul_in_valid !== 1'b0 || rsp_valid !== '0 || rsp_data !== '0) begin
      n_err++;
      $display("FAIL mid_async_clear: got ready=%b miv=%b rv=%b data=%h want all 0",
               req_ready, mul_in_valid, rsp_valid, rsp_data);
    end
    model_reset();
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== '0) begin
        n_err++;
        $display("FAIL mid_no_ghost%0d: got %b want 0", c, rsp_valid);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    rst_n     = 1'b0;
    test_reset();
    test_single();
    test_all4();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
